// File: rtl/event_counter_bank_if.sv
// event_counter_bank_if: snapshot valid/ready port of the event counter bank
interface event_counter_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                      snap_req;
  logic                      snap_ready;
  logic                      snap_valid;
  logic                      snap_drop;
  logic [CHANNELS*WIDTH-1:0] snap_data;
  modport master (output snap_req, snap_ready, input snap_valid, snap_data, snap_drop);
  modport slave  (input snap_req, snap_ready, output snap_valid, snap_data, snap_drop);
endinterface

// File: rtl/event_counter_bank.sv
// event_counter_bank: per-channel event counters with warm-up gating, wrap/saturate overflow and atomic snapshot
module event_counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int WARMUP   = 4,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       clr_i,
  output logic [CHANNELS*WIDTH-1:0] count_o,
  output logic [CHANNELS-1:0]       ovf_o,
  output logic                      armed_o,
  event_counter_bank_if.slave       snap
);
  typedef enum logic {WAIT, RUN} warm_t;
  typedef enum logic {IDLE, HOLD} snap_t;
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [8:0]       WARM = 9'(WARMUP);
  warm_t                      warm_q, warm_d;
  snap_t                      snap_q, snap_d;
  logic [7:0]                 wcnt_q, wcnt_d;
  logic [CHANNELS*WIDTH-1:0]  count_q, count_d, data_q, data_d;
  logic [CHANNELS-1:0]        ovf_q, ovf_d;
  logic                       drop_q, drop_d;
  // state registers; reset aborts warm-up, counting and any pending snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q  <= WAIT;
      snap_q  <= IDLE;
      wcnt_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      warm_q  <= warm_d;
      snap_q  <= snap_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end
  // next-state for warm-up and snapshot FSMs; RUN is entered on the WARMUP-th edge (first edge when WARMUP=0)
  always_comb begin
    wcnt_d = (warm_q == WAIT) ? wcnt_q + 8'd1 : wcnt_q;
    warm_d = (warm_q == RUN || {1'b0, wcnt_q} + 9'd1 >= WARM) ? RUN : WAIT;
    snap_d = (snap_q == IDLE) ? (snap.snap_req ? HOLD : IDLE)
                              : ((snap.snap_ready && !snap.snap_req) ? IDLE : HOLD);
    data_d = (snap.snap_req && (snap_q == IDLE || snap.snap_ready)) ? count_q : data_q;
    drop_d = snap_q == HOLD && snap.snap_req && !snap.snap_ready;
  end
  // channel update: clear beats count; overflow pulses in wrap mode, sticks in saturate mode
  always_comb begin
    count_d = count_q;
    ovf_d   = (SATURATE != 0) ? ovf_q : '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr_i[i]) begin
        count_d[i*WIDTH +: WIDTH] = '0;
        ovf_d[i]                  = 1'b0;
      end else if (armed_o && en_i[i]) begin
        if (count_q[i*WIDTH +: WIDTH] != MAX) begin
          count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH] + ONE;
        end else begin
          count_d[i*WIDTH +: WIDTH] = (SATURATE != 0) ? MAX : '0;
          ovf_d[i]                  = 1'b1;
        end
      end
    end
  end
  // outputs come straight from registers
  always_comb begin
    armed_o         = warm_q == RUN;
    count_o         = count_q;
    ovf_o           = ovf_q;
    snap.snap_valid = snap_q == HOLD;
    snap.snap_data  = data_q;
    snap.snap_drop  = drop_q;
  end
endmodule

// File: tb/tb_event_counter_bank.sv
// tb_event_counter_bank: directed checks of warm-up, wrap, saturate, snapshot and reset
module tb_event_counter_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en, clr;
  logic [7:0] count0, count1;
  logic [1:0] ovf0, ovf1;
  logic       armed0, armed1;
  int         errors = 0;
  int         checks = 0;
  event_counter_bank_if #(.CHANNELS(2), .WIDTH(4)) if0 ();
  event_counter_bank_if #(.CHANNELS(2), .WIDTH(4)) if1 ();
  event_counter_bank #(.WIDTH(4), .CHANNELS(2), .WARMUP(4), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr), .count_o(count0),
    .ovf_o(ovf0), .armed_o(armed0), .snap(if0));
  event_counter_bank #(.WIDTH(4), .CHANNELS(2), .WARMUP(4), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en_i(en), .clr_i(clr), .count_o(count1),
    .ovf_o(ovf1), .armed_o(armed1), .snap(if1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; en = 2'b00; clr = 2'b00;
    if0.snap_req = 1'b0; if0.snap_ready = 1'b0;
    if1.snap_req = 1'b0; if1.snap_ready = 1'b0;
    step(2);
    chk("rst_count", count0, 8'h00);
    chk("rst_ovf", ovf0, 2'b00);
    chk("rst_armed", armed0, 1'b0);
    chk("rst_valid", if0.snap_valid, 1'b0);
    chk("rst_data", if0.snap_data, 8'h00);
    chk("rst_drop", if0.snap_drop, 1'b0);
    en = 2'b11; reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("warm_armed", armed0, 1'b0);
      chk("warm_count", count0, 8'h00);
    end
    step(1);
    chk("warm_armed4", armed0, 1'b1);
    chk("warm_armed4_sat", armed1, 1'b1);
    chk("warm_count4", count0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("run_count", count0, {i[3:0], i[3:0]});
      chk("run_count_sat", count1, {i[3:0], i[3:0]});
    end
    clr = 2'b11; en = 2'b00; step(1);
    chk("clr_all", count0, 8'h00);
    clr = 2'b00; en = 2'b01; step(15);
    chk("wrap_15", count0, 8'h0F);
    chk("wrap_15_ovf", ovf0, 2'b00);
    chk("sat_15", count1, 8'h0F);
    step(1);
    chk("wrap_16", count0, 8'h00);
    chk("wrap_16_ovf", ovf0, 2'b01);
    chk("sat_16", count1, 8'h0F);
    chk("sat_16_ovf", ovf1, 2'b01);
    en = 2'b00; step(1);
    chk("wrap_ovf_pulse", ovf0, 2'b00);
    chk("sat_ovf_sticky", ovf1, 2'b01);
    en = 2'b01; step(4);
    chk("wrap_after", count0, 8'h04);
    chk("sat_20", count1, 8'h0F);
    chk("sat_20_ovf", ovf1, 2'b01);
    clr = 2'b01; step(1);
    chk("sat_clr", count1, 8'h00);
    chk("sat_clr_ovf", ovf1, 2'b00);
    chk("wrap_clr", count0, 8'h00);
    clr = 2'b11; en = 2'b00; step(1);
    clr = 2'b00; en = 2'b11; step(5);
    en = 2'b10; step(4);
    chk("pre_snap", count0, 8'h95);
    en = 2'b11; if0.snap_req = 1'b1; step(1);
    chk("snap_count", count0, 8'hA6);
    chk("snap_data", if0.snap_data, 8'h95);
    chk("snap_valid", if0.snap_valid, 1'b1);
    chk("snap_nodrop", if0.snap_drop, 1'b0);
    if0.snap_req = 1'b0; en = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("hold_data", if0.snap_data, 8'h95);
      chk("hold_valid", if0.snap_valid, 1'b1);
    end
    if0.snap_ready = 1'b1; step(1);
    chk("xfer_valid", if0.snap_valid, 1'b0);
    if0.snap_ready = 1'b0; if0.snap_req = 1'b1; step(1);
    chk("cap2_data", if0.snap_data, 8'hA6);
    chk("cap2_valid", if0.snap_valid, 1'b1);
    step(1);
    chk("drop_pulse", if0.snap_drop, 1'b1);
    chk("drop_data", if0.snap_data, 8'hA6);
    chk("drop_valid", if0.snap_valid, 1'b1);
    if0.snap_req = 1'b0; step(1);
    chk("drop_end", if0.snap_drop, 1'b0);
    en = 2'b01; step(1);
    chk("pre_b2b", count0, 8'hA7);
    en = 2'b00; if0.snap_req = 1'b1; if0.snap_ready = 1'b1; step(1);
    chk("b2b_data", if0.snap_data, 8'hA7);
    chk("b2b_valid", if0.snap_valid, 1'b1);
    chk("b2b_nodrop", if0.snap_drop, 1'b0);
    if0.snap_req = 1'b0; if0.snap_ready = 1'b0;
    reset = 1'b1; step(1);
    chk("mid_count", count0, 8'h00);
    chk("mid_ovf", ovf0, 2'b00);
    chk("mid_armed", armed0, 1'b0);
    chk("mid_valid", if0.snap_valid, 1'b0);
    chk("mid_data", if0.snap_data, 8'h00);
    chk("mid_drop", if0.snap_drop, 1'b0);
    reset = 1'b0; en = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("rewarm_armed", armed0, 1'b0);
      chk("rewarm_count", count0, 8'h00);
    end
    step(1);
    chk("rewarm_armed4", armed0, 1'b1);
    step(1);
    chk("rewarm_count", count0, 8'h11);
    chk("sat_if_idle", if1.snap_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/event_counter_bank.md
# event_counter_bank

Parametrised bank of independent per-channel event counters, the next generation of the team's single 4-bit enable counter. It adds a post-reset warm-up window during which counting is suppressed, so reset-phase activity is not counted. It also adds per-channel clear, selectable wrap or saturate overflow behaviour, and a valid/ready snapshot port that captures all channels atomically. It sits beside instrumented logic as a cycle/event statistics collector read by the testbench or a register block.

## Interface
- WIDTH, 8, counter width per channel (≥2)
- CHANNELS, 4, number of independent counters (≥1)
- WARMUP, 4, cycles after reset deassertion before counting is permitted (0..255)
- SATURATE, 0, 0 = counters wrap modulo 2^WIDTH; 1 = counters stick at all-ones
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  CHANNELS  per-channel count enable (bit i → channel i)
- clr  in  CHANNELS  per-channel synchronous clear
- count  out  CHANNELS*WIDTH  live counter values, channel i at bits [i*WIDTH +: WIDTH]
- ovf  out  CHANNELS  overflow indication per channel
- armed  out  1  high once warm-up has elapsed
- snap_req  in  1  request atomic capture of all counters
- snap_valid  out  1  snapshot data valid
- snap_ready  in  1  consumer accepts snapshot
- snap_data  out  CHANNELS*WIDTH  captured values, same packing as count
- snap_drop  out  1  one-cycle pulse: request lost because a snapshot was pending

## Operation
- Reset: count=0, ovf=0, armed=0, snap_valid=0, snap_data=0, snap_drop=0, warm-up counter=0. Reset mid-operation aborts everything, including a pending snapshot.
- Warm-up FSM has two states, WAIT and RUN.
  - In WAIT, the warm-up counter increments each cycle with reset low.
  - It moves to RUN when the counter reaches WARMUP. armed=1 in RUN.
  - WARMUP=0: RUN on the first edge after reset deasserts.
- Channel update per edge, in priority order:
  1. clr[i] → count=0, ovf[i]=0.
  2. Else, if armed and en[i]:
     - count < max → count+1.
     - count = max, SATURATE=0 → count=0 and ovf[i] pulses high for one cycle.
     - count = max, SATURATE=1 → count holds at max and ovf[i] is set sticky until clr[i] or reset.
  3. Else → hold.
- en is ignored while not armed; clr is honoured always.
- Snapshot FSM has two states, IDLE and HOLD.
  - IDLE with snap_req=1: snap_data ← current count (pre-update register values of that cycle). Go to HOLD; snap_valid=1.
  - HOLD: snap_data and snap_valid are stable until an edge with snap_ready=1.
    - snap_ready=1, snap_req=0 → IDLE, snap_valid=0.
    - snap_ready=1, snap_req=1 in the same cycle → back-to-back recapture; stay in HOLD with new data, no drop.
    - snap_req=1, snap_ready=0 → request ignored; snap_drop pulses for one cycle.
- Width rules: all arithmetic is WIDTH bits unsigned; the warm-up counter is 8 bits.

## Timing
- Count latency: en sampled at edge N → count updated after edge N. Same for clr and ovf.
- armed rises after the WARMUP-th edge with reset low.
- snapshot latency: snap_req at edge N → snap_valid and snap_data visible after edge N. The captured values exclude any increment at edge N.
- Transfer completes at the edge where snap_valid & snap_ready are both high.
- snap_drop is registered and appears one cycle after the dropped request edge.
- No combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH=4, CHANNELS=2, WARMUP=4 unless stated.

- Warm-up gating: hold en=2'b11 from reset release. armed rises after the 4th edge. Both counts stay 0 until then, then read 1, 2, 3 on the following edges.
- Wrap, SATURATE=0: drive ch0 15 enabled cycles from 0. count0 = 15. On the 16th edge count0 = 0 and ovf[0] pulses for exactly one cycle. ch1 with en=0 stays 0.
- Saturate, SATURATE=1: drive ch0 20 enabled cycles. count0 sticks at 15 and ovf[0] is sticky high. Pulse clr[0] with en[0]=1 → count0 = 0, ovf[0] = 0 (clear wins).
- Snapshot atomicity: ch0=5, ch1=9 with both enabled, pulse snap_req. snap_data = {9,5} while counts advance to {10,6}. Hold snap_ready=0 for 3 cycles and check the data is stable. Raise snap_ready → snap_valid=0 next cycle.
- Drop and back-to-back: in HOLD, snap_req with snap_ready=0 → snap_drop pulse, data unchanged. Then snap_req with snap_ready=1 → new capture, snap_valid stays 1, no drop.
- Reset mid-operation: assert reset during HOLD with counts non-zero. After the next edge, all outputs are 0 and armed=0, and the warm-up repeats its full 4 cycles.
